cv32e40s_mul_issue: RTL and testbench
=====================================

// Module: cv32e40s_mul_issue
// PURPOSE
//  EX-stage issue/retire stage directly upstream of the 32x32 multiplier. Accepts one
//  MUL/MULH/MULHSU/MULHU from ID/EX and decodes funct3 into multiplier operator and signed mode.
//  Holds operands stable across the multiplier's 1-cycle (MUL) or 4-cycle (MULH*) sequence.
//  Returns the 32-bit result with its rd tag to writeback over a valid/ready handshake.
// PARAMETERS
//  TAG_W  5  width of destination-register tag carried alongside the operation
// PORTS
//  clk               in   1      clock; the only clock
//  rst_n             in   1      asynchronous, active-low reset
//  valid_i           in   1      ID/EX presents a multiply op
//  ready_o           out  1      stage accepts op this cycle (accept = valid_i && ready_o)
//  funct3_i          in   3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx never presented
//  rs1_i, rs2_i      in   32     operands a, b
//  rd_i              in   TAG_W  destination tag
//  kill_i            in   1      flush: abandon op in flight and any held result
//  mul_valid_o       out  1      to multiplier valid_i; low = kill/idle
//  mul_operator_o    out  mul_opcode_e  MUL_M32 for funct3 000, MUL_H otherwise
//  mul_signed_mode_o out  2      [0]=op_a signed, [1]=op_b signed: MULH 11, MULHSU 01, MULHU/MUL 00
//  mul_op_a_o        out  32     latched rs1
//  mul_op_b_o        out  32     latched rs2
//  mul_result_i      in   32     multiplier result_o
//  mul_valid_i       in   1      multiplier valid_o
//  mul_done_i        in   1      multiplier ready_o
//  mul_ready_o       out  1      to multiplier ready_i
//  wb_valid_o        out  1      result valid to writeback
//  wb_ready_i        in   1      writeback accepts
//  wb_result_o       out  32     result
//  wb_rd_o           out  TAG_W  destination tag
// BEHAVIOUR
//  Reset: state IDLE; operand/tag/result regs 0; ready_o=1; mul_valid_o, wb_valid_o=0.
//  FSM IDLE: ready_o=1; on accept latch rs1/rs2/funct3/rd -> BUSY.
//  FSM BUSY: mul_valid_o=1, outputs driven from latched regs only (inputs may change).
//   Completion = mul_valid_i && mul_ready_o (multiplier asserts mul_done_i the same cycle).
//   On completion: ready_o=1, so a new op can be accepted the same cycle (back-to-back,
//   stay BUSY); else -> IDLE. Without completion: ready_o=0, hold.
//  Latency (accept at cycle N, wb_ready_i=1): MUL result at N+1; MULH* at N+4 (4 multiplier steps).
//  Backpressure: wb_ready_i=0 holds the multiplier in its final step; operands, result, tag stable.
//  kill_i (any state, priority over everything): mul_valid_o=0 and wb_valid_o=0 that cycle,
//   ready_o=0, accept suppressed; next state IDLE; held result discarded; multiplier resets its FSM.
//  mul_done_i with mul_valid_o=0 ignored. funct3 1xx: accepted, treated as MUL (no assertion fired).
//  Async reset mid-op: immediate return to reset values; no partial result ever reaches wb.
// CONFIGURATION
//  CV32E40S_MUL_RESULT_REG_EN defined: one-entry output register (result+tag+valid).
//   mul_ready_o = !out_valid || wb_ready_i; completion loads the register; wb_* driven from it.
//   Latency +1 (MUL N+2, MULH* N+5); kill_i clears out_valid.
//  Undefined: combinational path; wb_valid_o = BUSY && mul_valid_i && !kill_i,
//   mul_ready_o = wb_ready_i, wb_result_o = mul_result_i, wb_rd_o = latched tag.
// STRUCTURE
//  cv32e40s_pkg: add mul_issue_state_e {MI_IDLE, MI_BUSY}; funct3 constants
//   (FUNCT3_MUL..FUNCT3_MULHU); reuse existing mul_opcode_e.
//  funct3 decode as a package function; no sub-module: the multiplier is instantiated alongside
//   by the EX stage, not inside this block.
// TESTING
//  MUL rs1=7, rs2=6, wb_ready_i=1 -> wb_result_o=0x0000002A, wb_valid_o at N+1 (N+2 with macro).
//  MULH 0xFFFFFFFE x 0x00000003 -> signed_mode 11, 0xFFFFFFFF at N+4; ready_o=0 cycles N+1..N+3.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> mode 00, 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> mode 01, 0xFFFFFFFF.
//  MULH with wb_ready_i=0 for 3 extra cycles -> wb_valid_o held, result/tag stable, ready_o=0; then
//   wb_ready_i=1 with valid_i MUL 3x5 -> both retire, 0x0000000F one cycle later.
//  kill_i in BUSY step 2 of MULH -> mul_valid_o=0 that cycle, no wb_valid_o, IDLE next; new MUL 2x2 -> 4.
//  rst_n low mid-MULH -> all outputs reset values asynchronously; after release first op completes normally.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
// Shared types for the multiplier issue stage: multiplier opcode, issue FSM state,
// funct3 encodings and the funct3 -> (operator, signed mode) decode.
package cv32e40s_pkg;

  typedef enum logic [0:0] {
    MUL_M32 = 1'b0,
    MUL_H   = 1'b1
  } mul_opcode_e;

  typedef enum logic [0:0] {
    MI_IDLE = 1'b0,
    MI_BUSY = 1'b1
  } mul_issue_state_e;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  typedef struct packed {
    mul_opcode_e op;
    logic [1:0]  signed_mode;  // [0]=op_a signed, [1]=op_b signed
  } mul_decode_t;

  // Reserved 1xx encodings fall through to the low-word multiply.
  function automatic mul_decode_t mul_decode(input logic [2:0] funct3);
    mul_decode_t d;
    d.op          = MUL_H;
    d.signed_mode = 2'b00;
    case (funct3)
      FUNCT3_MULH:   d.signed_mode = 2'b11;
      FUNCT3_MULHSU: d.signed_mode = 2'b01;
      FUNCT3_MULHU:  d.signed_mode = 2'b00;
      default:       d.op          = MUL_M32;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cv32e40s_mul_issue.sv
// EX-stage issue/retire stage in front of the 32x32 multiplier.
// Optional output register enabled by defining CV32E40S_MUL_RESULT_REG_EN.
module cv32e40s_mul_issue
  import cv32e40s_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      rs1_i,
  input  logic [31:0]      rs2_i,
  input  logic [TAG_W-1:0] rd_i,
  input  logic             kill_i,
  output logic             mul_valid_o,
  output mul_opcode_e      mul_operator_o,
  output logic [1:0]       mul_signed_mode_o,
  output logic [31:0]      mul_op_a_o,
  output logic [31:0]      mul_op_b_o,
  input  logic [31:0]      mul_result_i,
  input  logic             mul_valid_i,
  input  logic             mul_done_i,
  output logic             mul_ready_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic [TAG_W-1:0] wb_rd_o
);

  mul_issue_state_e state_q, state_d;
  logic [31:0]      op_a_q, op_b_q;
  logic [2:0]       funct3_q;
  logic [TAG_W-1:0] rd_q;
  logic             busy, complete, accept;
  mul_decode_t      dec;
  logic             unused_done;

  // Completion is fully determined by valid/ready; done is redundant with it.
  assign unused_done = mul_done_i;

  assign busy        = (state_q == MI_BUSY);
  assign mul_valid_o = busy && !kill_i;
  assign complete    = mul_valid_o && mul_valid_i && mul_ready_o;
  assign ready_o     = !kill_i && (!busy || complete);
  assign accept      = valid_i && ready_o;

  assign dec               = mul_decode(funct3_q);
  assign mul_operator_o    = dec.op;
  assign mul_signed_mode_o = dec.signed_mode;
  assign mul_op_a_o        = op_a_q;
  assign mul_op_b_o        = op_b_q;

  always_comb begin
    state_d = state_q;
    if (kill_i)        state_d = MI_IDLE;
    else if (accept)   state_d = MI_BUSY;
    else if (complete) state_d = MI_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MI_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q   <= rs1_i;
        op_b_q   <= rs2_i;
        funct3_q <= funct3_i;
        rd_q     <= rd_i;
      end
    end
  end

`ifdef CV32E40S_MUL_RESULT_REG_EN
  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic [TAG_W-1:0] out_rd_q;

  // A full register stalls the multiplier in its final step until writeback drains it.
  assign mul_ready_o = !out_valid_q || wb_ready_i;
  assign wb_valid_o  = out_valid_q && !kill_i;
  assign wb_result_o = out_result_q;
  assign wb_rd_o     = out_rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else if (kill_i) begin
      out_valid_q <= 1'b0;
    end else if (complete) begin
      out_valid_q  <= 1'b1;
      out_result_q <= mul_result_i;
      out_rd_q     <= rd_q;
    end else if (wb_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign mul_ready_o = wb_ready_i;
  assign wb_valid_o  = mul_valid_o && mul_valid_i;
  assign wb_result_o = mul_result_i;
  assign wb_rd_o     = rd_q;
`endif

endmodule

// File: tb/tb_cv32e40s_mul_issue.sv
// Self-checking bench for cv32e40s_mul_issue with a behavioural 1/4-step multiplier.
module tb_cv32e40s_mul_issue;
  import cv32e40s_pkg::*;

  localparam int TAG_W = 5;
`ifdef CV32E40S_MUL_RESULT_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_i = 1'b0, ready_o;
  logic [2:0]       funct3_i = '0;
  logic [31:0]      rs1_i = '0, rs2_i = '0;
  logic [TAG_W-1:0] rd_i = '0;
  logic             kill_i = 1'b0;
  logic             mul_valid_o;
  mul_opcode_e      mul_operator_o;
  logic [1:0]       mul_signed_mode_o;
  logic [31:0]      mul_op_a_o, mul_op_b_o;
  logic [31:0]      mul_result_i;
  logic             mul_valid_i, mul_done_i, mul_ready_o;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b1;
  logic [31:0]      wb_result_o;
  logic [TAG_W-1:0] wb_rd_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cv32e40s_mul_issue #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .kill_i(kill_i),
    .mul_valid_o(mul_valid_o), .mul_operator_o(mul_operator_o),
    .mul_signed_mode_o(mul_signed_mode_o), .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o),
    .mul_result_i(mul_result_i), .mul_valid_i(mul_valid_i), .mul_done_i(mul_done_i),
    .mul_ready_o(mul_ready_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_rd_o(wb_rd_o)
  );

  // Multiplier stand-in: low word in one step, high word after four; holds when not ready.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input mul_opcode_e op, input logic [1:0] mode);
    logic [63:0] ax, bx, p;
    ax = {{32{mode[0] & a[31]}}, a};
    bx = {{32{mode[1] & b[31]}}, b};
    p  = ax * bx;
    return (op == MUL_M32) ? p[31:0] : p[63:32];
  endfunction

  int mstep;
  always_comb begin
    mul_valid_i  = mul_valid_o && ((mul_operator_o == MUL_M32) || (mstep == 3));
    mul_done_i   = mul_valid_i && mul_ready_o;
    mul_result_i = mul_model(mul_op_a_o, mul_op_b_o, mul_operator_o, mul_signed_mode_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        mstep <= 0;
    else if (!mul_valid_o || (mul_valid_i && mul_ready_o)) mstep <= 0;
    else if (!mul_valid_i)                             mstep <= mstep + 1;
  end

  // Architectural result of the RISC-V M multiply family.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd1:    p = sa * sb;
      3'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called #1 after a negedge with an op presented; returns cycles until wb_valid_o.
  task automatic wait_wb(output int lat);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    lat = 1;
    while (!wb_valid_o && lat < 16) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] rd);
    valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    total++; if (mul_valid_o !== 1'b0) begin bad++; $display("FAIL reset_mul_valid: got %b want 0", mul_valid_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
    total++; if ({mul_op_a_o, mul_op_b_o, wb_rd_o} !== '0) begin bad++;
      $display("FAIL reset_regs: got %h %h %h want 0", mul_op_a_o, mul_op_b_o, wb_rd_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int lat;
    present(3'b000, 32'd7, 32'd6, 5'd5);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mul_ready: got %b want 1", ready_o); end
    wait_wb(lat);
    total++; if (lat != 1 + EXTRA) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat, 1 + EXTRA); end
    total++; if (wb_result_o !== 32'h2A || wb_rd_o !== 5'd5) begin bad++;
      $display("FAIL mul_result: got %h rd %0d want 0000002a rd 5", wb_result_o, wb_rd_o); end
    tick();
  endtask

  task automatic test_mulh();
    present(3'b001, 32'hFFFF_FFFE, 32'h3, 5'd7);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
    #1;
    total++; if (mul_operator_o !== MUL_H || mul_signed_mode_o !== 2'b11 || mul_op_a_o !== 32'hFFFF_FFFE) begin bad++;
      $display("FAIL mulh_decode: got op %0d mode %b a %h want 1 11 fffffffe", mul_operator_o, mul_signed_mode_o, mul_op_a_o); end
    for (int k = 1; k <= 3; k++) begin
      total++; if (ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin bad++;
        $display("FAIL mulh_busy_n%0d: got ready %b wb %b want 0 0", k, ready_o, wb_valid_o); end
      @(negedge clk); #1;
    end
    if (EXTRA != 0) begin @(negedge clk); #1; end
    total++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'hFFFF_FFFF || wb_rd_o !== 5'd7) begin bad++;
      $display("FAIL mulh_result: got v %b %h rd %0d want 1 ffffffff 7", wb_valid_o, wb_result_o, wb_rd_o); end
    tick();
  endtask

  task automatic test_mulhu_mulhsu();
    int lat;
    present(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    wait_wb(lat);
    total++; if (lat != 4 + EXTRA || mul_signed_mode_o !== 2'b00 || wb_result_o !== 32'hFFFF_FFFE) begin bad++;
      $display("FAIL mulhu: got lat %0d mode %b %h want %0d 00 fffffffe", lat, mul_signed_mode_o, wb_result_o, 4 + EXTRA); end
    tick();
    present(3'b010, 32'hFFFF_FFFF, 32'h2, 5'd12);
    wait_wb(lat);
    total++; if (lat != 4 + EXTRA || mul_signed_mode_o !== 2'b01 || wb_result_o !== 32'hFFFF_FFFF) begin bad++;
      $display("FAIL mulhsu: got lat %0d mode %b %h want %0d 01 ffffffff", lat, mul_signed_mode_o, wb_result_o, 4 + EXTRA); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    wb_ready_i = 1'b0;
    present(3'b001, 32'hFFFF_FFFE, 32'h3, 5'd21);
    wait_wb(lat);
    total++; if (lat != 4 + EXTRA) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, 4 + EXTRA); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      total++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'hFFFF_FFFF || wb_rd_o !== 5'd21) begin bad++;
        $display("FAIL bp_hold%0d: got v %b %h rd %0d want 1 ffffffff 21", k, wb_valid_o, wb_result_o, wb_rd_o); end
`ifndef CV32E40S_MUL_RESULT_REG_EN
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", k, ready_o); end
`endif
    end
    @(negedge clk);
    wb_ready_i = 1'b1;
    present(3'b000, 32'd3, 32'd5, 5'd22);
    total++; if (ready_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_result_o !== 32'hFFFF_FFFF) begin bad++;
      $display("FAIL bp_release: got ready %b v %b %h want 1 1 ffffffff", ready_o, wb_valid_o, wb_result_o); end
    wait_wb(lat);
    total++; if (lat != 1 + EXTRA || wb_result_o !== 32'hF || wb_rd_o !== 5'd22) begin bad++;
      $display("FAIL b2b_result: got lat %0d %h rd %0d want %0d 0000000f 22", lat, wb_result_o, wb_rd_o, 1 + EXTRA); end
    tick();
  endtask

  task automatic test_kill();
    int lat;
    present(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    tick();
    present(3'b000, 32'd9, 32'd9, 5'd30);
    valid_i = 1'b0;
    tick();
    kill_i = 1'b1; valid_i = 1'b1;
    #1;
    total++; if (mul_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || ready_o !== 1'b0) begin bad++;
      $display("FAIL kill_cycle: got mv %b wb %b ready %b want 0 0 0", mul_valid_o, wb_valid_o, ready_o); end
    tick();
    kill_i = 1'b0; valid_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1 || mul_valid_o !== 1'b0 || wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL kill_idle: got ready %b mv %b wb %b want 1 0 0", ready_o, mul_valid_o, wb_valid_o); end
    @(negedge clk);
    present(3'b000, 32'd2, 32'd2, 5'd4);
    wait_wb(lat);
    total++; if (lat != 1 + EXTRA || wb_result_o !== 32'd4 || wb_rd_o !== 5'd4) begin bad++;
      $display("FAIL kill_recover: got lat %0d %h rd %0d want %0d 4 4", lat, wb_result_o, wb_rd_o, 1 + EXTRA); end
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    present(3'b001, 32'hFFFF_FFFE, 32'h3, 5'd9);
    tick();
    valid_i = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1 || mul_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || mul_op_a_o !== '0 || wb_rd_o !== '0) begin bad++;
      $display("FAIL arst_values: got ready %b mv %b wb %b a %h rd %0d want 1 0 0 0 0", ready_o, mul_valid_o, wb_valid_o, mul_op_a_o, wb_rd_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    present(3'b000, 32'h1234, 32'h10, 5'd13);
    wait_wb(lat);
    total++; if (lat != 1 + EXTRA || wb_result_o !== 32'h12340 || wb_rd_o !== 5'd13) begin bad++;
      $display("FAIL arst_recover: got lat %0d %h rd %0d want %0d 12340 13", lat, wb_result_o, wb_rd_o, 1 + EXTRA); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0]      exp_res[$];
    logic [TAG_W-1:0] exp_rd[$];
    logic [31:0]      er;
    logic [TAG_W-1:0] ed;
    int sent = 0, got = 0, cyc = 0;
    bit acc;
    while (got < 60 && cyc < 4000) begin
      if (!valid_i && sent < 60 && $urandom_range(0, 3) != 0) begin
        valid_i  = 1'b1;
        funct3_i = 3'($urandom_range(0, 7));
        rs1_i    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        rs2_i    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        rd_i     = TAG_W'($urandom);
      end
      wb_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (wb_valid_o && wb_ready_i) begin
        total++;
        if (exp_res.size() == 0) begin
          bad++; $display("FAIL rnd_spurious: got result %h with nothing outstanding", wb_result_o);
        end else begin
          er = exp_res.pop_front();
          ed = exp_rd.pop_front();
          if (wb_result_o !== er || wb_rd_o !== ed) begin bad++;
            $display("FAIL rnd_retire%0d: got %h rd %0d want %h rd %0d", got, wb_result_o, wb_rd_o, er, ed); end
        end
        got++;
      end
      acc = valid_i && ready_o;
      if (acc) begin
        exp_res.push_back(ref_result(funct3_i, rs1_i, rs2_i));
        exp_rd.push_back(rd_i);
        sent++;
      end
      tick();
      if (acc) valid_i = 1'b0;
      cyc++;
    end
    total++; if (got != 60) begin bad++; $display("FAIL rnd_count: got %0d retired want 60", got); end
    wb_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_mulhu_mulhsu();
    test_backpressure();
    test_kill();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
